mont_modexp_seq: RTL and testbench

- Left-to-right square-and-multiply sequencer computing base^exp mod N.
- Sits directly upstream of montgomery_top, drives its a/b/taken inputs, and consumes its result/ready_out via given.
- Accepts one exponentiation job at a time from a host-side taken/ready_in handshake and returns the result on a ready_out/given handshake.
- Keeps exactly one multiplication outstanding in montgomery_top at any time.

---
 rtl/mont_pkg.sv | 25 ++
 rtl/mont_modexp_seq_msb_index.sv | 22 ++
 rtl/mont_modexp_seq.sv | 153 +++++++++++++++
 tb/tb_mont_modexp_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation sequencer.
// The modulus here must match the one hard-wired into montgomery_top.
package mont_pkg;

  localparam int MONT_W = 64;
  localparam int MONT_EXP_W = 64;
  localparam logic [MONT_W-1:0] N_MOD = 64'hFFFF_FFFF_FFFF_FFF1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE_SQ,
    ST_WAIT_SQ,
    ST_ISSUE_MUL,
    ST_WAIT_MUL,
    ST_DONE
  } modexp_state_t;

  // One conditional subtract suffices because any W-bit value is below 2*n.
  function automatic logic [MONT_W-1:0] reduce_once(input logic [MONT_W-1:0] x,
                                                    input logic [MONT_W-1:0] n);
    return (x >= n) ? (x - n) : x;
  endfunction

endpackage

// File: rtl/mont_modexp_seq_msb_index.sv
// Priority encoder: index of the highest set bit of vec_i, plus an all-zero flag.
module msb_index #(
  parameter int EXP_W = 64
) (
  input  logic [EXP_W-1:0]         vec_i,
  output logic [$clog2(EXP_W)-1:0] idx_o,
  output logic                     zero_o
);

  localparam int IW = $clog2(EXP_W);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < EXP_W; i++) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign zero_o = ~|vec_i;

endmodule

// File: rtl/mont_modexp_seq.sv
// Left-to-right square-and-multiply sequencer driving montgomery_top,
// keeping exactly one modular multiplication in flight at a time.
module mont_modexp_seq
  import mont_pkg::*;
#(
  parameter int             W     = MONT_W,
  parameter int             EXP_W = MONT_EXP_W,
  parameter logic [W-1:0]   N     = N_MOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     base,
  input  logic [EXP_W-1:0] exp,
  input  logic             taken,
  output logic             ready_in,
  output logic [W-1:0]     result,
  output logic             ready_out,
  input  logic             given,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  output logic             mul_taken,
  input  logic             mul_ready_in,
  input  logic [W-1:0]     mul_result,
  input  logic             mul_ready_out,
  output logic             mul_given,
  output logic             stale_err
);

  localparam int IW = $clog2(EXP_W);

  modexp_state_t    state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [W-1:0]     base_r_q, base_r_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             stale_q, stale_d;

  logic [IW-1:0]    msb_idx;
  logic             exp_zero;

  msb_index #(.EXP_W(EXP_W)) u_msb_index (
    .vec_i  (exp_q),
    .idx_o  (msb_idx),
    .zero_o (exp_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      exp_q    <= '0;
      base_r_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      base_r_q <= base_r_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      stale_q  <= stale_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    base_r_d  = base_r_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    ready_in  = 1'b0;
    ready_out = 1'b0;
    result    = '0;
    mul_a     = '0;
    mul_b     = '0;
    mul_taken = 1'b0;
    // Any multiplier result outside a wait state has no owner: drop it and flag.
    stale_d   = stale_q |
                (mul_ready_out && (state_q != ST_WAIT_SQ) && (state_q != ST_WAIT_MUL));

    unique case (state_q)
      ST_IDLE: begin
        ready_in = 1'b1;
        if (taken) begin
          exp_d    = exp;
          base_r_d = reduce_once(base, N);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (exp_zero) begin
          acc_d   = W'(1);
          state_d = ST_DONE;
        end else begin
          acc_d = base_r_q;
          if (msb_idx == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = msb_idx - 1'b1;
            state_d = ST_ISSUE_SQ;
          end
        end
      end
      ST_ISSUE_SQ: begin
        mul_a     = acc_q;
        mul_b     = acc_q;
        mul_taken = 1'b1;
        if (mul_ready_in) state_d = ST_WAIT_SQ;
      end
      ST_WAIT_SQ: begin
        if (mul_ready_out) begin
          acc_d = mul_result;
          if (exp_q[idx_q]) begin
            state_d = ST_ISSUE_MUL;
          end else if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_ISSUE_SQ;
          end
        end
      end
      ST_ISSUE_MUL: begin
        mul_a     = acc_q;
        mul_b     = base_r_q;
        mul_taken = 1'b1;
        if (mul_ready_in) state_d = ST_WAIT_MUL;
      end
      ST_WAIT_MUL: begin
        if (mul_ready_out) begin
          acc_d = mul_result;
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_ISSUE_SQ;
          end
        end
      end
      ST_DONE: begin
        ready_out = 1'b1;
        result    = acc_q;
        if (given) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The multiplier is never backpressured outside reset.
  assign mul_given = rst_n;
  assign stale_err = stale_q;

endmodule

// File: tb/tb_mont_modexp_seq.sv
// Directed bench for mont_modexp_seq with a behavioural fixed-latency modular multiplier.
module tb_mont_modexp_seq;

  localparam logic [63:0] NM = 64'hFFFF_FFFF_FFFF_FFF1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] base = '0;
  logic [63:0] exp = '0;
  logic        taken = 1'b0;
  logic        ready_in;
  logic [63:0] result;
  logic        ready_out;
  logic        given = 1'b0;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic        mul_taken;
  logic        mul_ready_in = 1'b1;
  logic [63:0] mul_result = '0;
  logic        mul_ready_out = 1'b0;
  logic        mul_given;
  logic        stale_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mont_modexp_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .base          (base),
    .exp           (exp),
    .taken         (taken),
    .ready_in      (ready_in),
    .result        (result),
    .ready_out     (ready_out),
    .given         (given),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_taken     (mul_taken),
    .mul_ready_in  (mul_ready_in),
    .mul_result    (mul_result),
    .mul_ready_out (mul_ready_out),
    .mul_given     (mul_given),
    .stale_err     (stale_err)
  );

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, NM});
  endfunction

  // Multiplier model: handshake values sampled mid-cycle, outputs updated just after the edge.
  int          xfers = 0;
  int          sq_xfers = 0;
  logic        hs_s = 1'b0;
  logic        gv_s = 1'b0;
  logic [63:0] a_s = '0;
  logic [63:0] b_s = '0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_res = '0;

  always @(negedge clk) begin
    hs_s = mul_taken && mul_ready_in;
    gv_s = mul_given;
    a_s  = mul_a;
    b_s  = mul_b;
  end

  always @(posedge clk) begin
    #1;
    if (mul_ready_out && gv_s) begin
      mul_ready_out = 1'b0;
      mul_ready_in  = 1'b1;
    end
    if (hs_s) begin
      m_busy       = 1'b1;
      m_cnt        = 3;
      m_res        = mulmod(a_s, b_s);
      mul_ready_in = 1'b0;
      xfers++;
      if (a_s == b_s) sq_xfers++;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        mul_ready_out = 1'b1;
        mul_result    = m_res;
        m_busy        = 1'b0;
      end else begin
        m_cnt--;
      end
    end
  end

  task automatic do_job(input logic [63:0] b, input logic [63:0] e, input bit give,
                        output logic [63:0] res, output int cyc, output int nx,
                        output int nsq, output bit tmo);
    int x0;
    int s0;
    x0  = xfers;
    s0  = sq_xfers;
    tmo = 1'b1;
    cyc = 0;
    @(negedge clk);
    base  = b;
    exp   = e;
    taken = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      taken = 1'b0;
      cyc++;
      if (ready_out) begin
        tmo = 1'b0;
        break;
      end
    end
    res = result;
    nx  = xfers - x0;
    nsq = sq_xfers - s0;
    if (give) begin
      given = 1'b1;
      @(negedge clk);
      given = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready_out: got %b expected 0", ready_out); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (mul_a !== 64'd0 || mul_b !== 64'd0) begin failures++; $display("FAIL reset_mul_ab: got %h/%h expected 0/0", mul_a, mul_b); end
    checks++; if (mul_taken !== 1'b0) begin failures++; $display("FAIL reset_mul_taken: got %b expected 0", mul_taken); end
    checks++; if (stale_err !== 1'b0) begin failures++; $display("FAIL reset_stale_err: got %b expected 0", stale_err); end
    checks++; if (mul_given !== 1'b0) begin failures++; $display("FAIL reset_mul_given: got %b expected 0", mul_given); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mul_given !== 1'b1) begin failures++; $display("FAIL post_reset_mul_given: got %b expected 1", mul_given); end
    checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL post_reset_ready_in: got %b expected 1", ready_in); end
  endtask

  task automatic test_exp_zero();
    logic [63:0] r; int c; int nx; int nsq; bit t;
    do_job(64'd3, 64'd0, 1'b1, r, c, nx, nsq, t);
    $display("job 3^0: result=%h cycles=%0d xfers=%0d", r, c, nx);
    checks++; if (t) begin failures++; $display("FAIL exp0_timeout: got timeout expected ready_out"); end
    checks++; if (r !== 64'd1) begin failures++; $display("FAIL exp0_result: got %h expected 1", r); end
    checks++; if (c != 2) begin failures++; $display("FAIL exp0_latency: got %0d expected 2", c); end
    checks++; if (nx != 0) begin failures++; $display("FAIL exp0_xfers: got %0d expected 0", nx); end
  endtask

  task automatic test_exp_one();
    logic [63:0] r; int c; int nx; int nsq; bit t;
    do_job(64'd5, 64'd1, 1'b1, r, c, nx, nsq, t);
    $display("job 5^1: result=%h cycles=%0d xfers=%0d", r, c, nx);
    checks++; if (t || r !== 64'd5) begin failures++; $display("FAIL exp1_result: got %h (tmo=%0b) expected 5", r, t); end
    checks++; if (c != 2) begin failures++; $display("FAIL exp1_latency: got %0d expected 2", c); end
    checks++; if (nx != 0) begin failures++; $display("FAIL exp1_xfers: got %0d expected 0", nx); end
    do_job(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, r, c, nx, nsq, t);
    $display("job (2^64-1)^1: result=%h cycles=%0d xfers=%0d", r, c, nx);
    checks++; if (t || r !== 64'hE) begin failures++; $display("FAIL exp1_reduce: got %h (tmo=%0b) expected e", r, t); end
  endtask

  task automatic test_square_multiply();
    logic [63:0] r; int c; int nx; int nsq; bit t;
    do_job(64'd3, 64'd13, 1'b1, r, c, nx, nsq, t);
    $display("job 3^13: result=%h cycles=%0d xfers=%0d squares=%0d", r, c, nx, nsq);
    checks++; if (t || r !== 64'h1853D3) begin failures++; $display("FAIL sm_3_13_result: got %h (tmo=%0b) expected 1853d3", r, t); end
    checks++; if (nx != 5) begin failures++; $display("FAIL sm_3_13_xfers: got %0d expected 5", nx); end
    checks++; if (nsq != 3) begin failures++; $display("FAIL sm_3_13_squares: got %0d expected 3", nsq); end
    do_job(NM - 64'd1, 64'd2, 1'b1, r, c, nx, nsq, t);
    $display("job (N-1)^2: result=%h cycles=%0d xfers=%0d", r, c, nx);
    checks++; if (t || r !== 64'd1) begin failures++; $display("FAIL sm_nm1_sq_result: got %h (tmo=%0b) expected 1", r, t); end
    checks++; if (nx != 1) begin failures++; $display("FAIL sm_nm1_sq_xfers: got %0d expected 1", nx); end
  endtask

  task automatic test_boundaries();
    logic [63:0] r; int c; int nx; int nsq; bit t;
    do_job(64'hFFFF_FFFF_FFFF_FFF2, 64'd5, 1'b1, r, c, nx, nsq, t);
    $display("job (N+1)^5: result=%h cycles=%0d xfers=%0d", r, c, nx);
    checks++; if (t || r !== 64'd1) begin failures++; $display("FAIL bnd_np1_result: got %h (tmo=%0b) expected 1", r, t); end
    checks++; if (nx != 3) begin failures++; $display("FAIL bnd_np1_xfers: got %0d expected 3", nx); end
    do_job(64'd2, 64'd64, 1'b1, r, c, nx, nsq, t);
    $display("job 2^64: result=%h cycles=%0d xfers=%0d squares=%0d", r, c, nx, nsq);
    checks++; if (t || r !== 64'hF) begin failures++; $display("FAIL bnd_2_64_result: got %h (tmo=%0b) expected f", r, t); end
    checks++; if (nx != 6 || nsq != 6) begin failures++; $display("FAIL bnd_2_64_ops: got %0d/%0d expected 6/6", nx, nsq); end
  endtask

  task automatic test_hold_result();
    logic [63:0] r; int c; int nx; int nsq; bit t;
    do_job(64'd7, 64'd2, 1'b0, r, c, nx, nsq, t);
    $display("job 7^2 (held): result=%h cycles=%0d xfers=%0d", r, c, nx);
    checks++; if (t || r !== 64'd49) begin failures++; $display("FAIL hold_result_initial: got %h (tmo=%0b) expected 31", r, t); end
    base  = 64'd2;
    exp   = 64'd3;
    taken = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (ready_out !== 1'b1 || result !== 64'd49) begin failures++; $display("FAIL hold_stable cyc%0d: got %b/%h expected 1/31", i, ready_out, result); end
      checks++; if (ready_in !== 1'b0 || mul_taken !== 1'b0) begin failures++; $display("FAIL hold_idle_if cyc%0d: got ready_in=%b mul_taken=%b expected 0/0", i, ready_in, mul_taken); end
    end
    taken = 1'b0;
    given = 1'b1;
    @(negedge clk);
    given = 1'b0;
    $display("hold released: ready_out=%b ready_in=%b", ready_out, ready_in);
    checks++; if (ready_out !== 1'b0 || ready_in !== 1'b1) begin failures++; $display("FAIL hold_release: got %b/%b expected 0/1", ready_out, ready_in); end
    do_job(64'd2, 64'd3, 1'b1, r, c, nx, nsq, t);
    $display("job 2^3: result=%h cycles=%0d xfers=%0d", r, c, nx);
    checks++; if (t || r !== 64'd8) begin failures++; $display("FAIL hold_next_job: got %h (tmo=%0b) expected 8", r, t); end
    checks++; if (nx != 2) begin failures++; $display("FAIL hold_next_xfers: got %0d expected 2", nx); end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] r; int c; int nx; int nsq; bit t; int x0; bit seen;
    x0 = xfers;
    seen = 1'b0;
    @(negedge clk);
    base  = 64'd3;
    exp   = 64'd13;
    taken = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      taken = 1'b0;
      if (xfers != x0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL midrst_no_square: got none expected first square transfer"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("mid-op reset released: ready_in=%b ready_out=%b stale_err=%b", ready_in, ready_out, stale_err);
    checks++; if (ready_in !== 1'b1 || ready_out !== 1'b0 || mul_taken !== 1'b0) begin failures++; $display("FAIL midrst_idle: got ready_in=%b ready_out=%b mul_taken=%b expected 1/0/0", ready_in, ready_out, mul_taken); end
    checks++; if (stale_err !== 1'b0) begin failures++; $display("FAIL midrst_stale_clear: got %b expected 0", stale_err); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stale_err) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL midrst_stale_set: got %b expected 1", stale_err); end
    repeat (2) @(negedge clk);
    do_job(64'd3, 64'd13, 1'b1, r, c, nx, nsq, t);
    $display("job 3^13 after reset: result=%h cycles=%0d xfers=%0d stale_err=%b", r, c, nx, stale_err);
    checks++; if (t || r !== 64'h1853D3) begin failures++; $display("FAIL midrst_rerun: got %h (tmo=%0b) expected 1853d3", r, t); end
    checks++; if (stale_err !== 1'b1) begin failures++; $display("FAIL midrst_sticky: got %b expected 1", stale_err); end
  endtask

  initial begin
    test_reset();
    test_exp_zero();
    test_exp_one();
    test_square_multiply();
    test_boundaries();
    test_hold_result();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
